// File: rtl/decbin_pkg.sv
// decbin_pkg: shared FSM encoding and CABAC probability tables for the bin decoder
package decbin_pkg;
  typedef enum logic [2:0] {IDLE, INIT, RD, DEC, RENORM, RESP} state_t;
  localparam logic [8:0] RANGE_INIT = 9'd510;
  localparam logic [7:0] LPS_TAB [64][4] = '{
    '{8'd128, 8'd176, 8'd208, 8'd240}, '{8'd128, 8'd167, 8'd197, 8'd227},
    '{8'd128, 8'd158, 8'd187, 8'd216}, '{8'd123, 8'd150, 8'd178, 8'd205},
    '{8'd116, 8'd142, 8'd169, 8'd195}, '{8'd111, 8'd135, 8'd160, 8'd185},
    '{8'd105, 8'd128, 8'd152, 8'd175}, '{8'd100, 8'd122, 8'd144, 8'd166},
    '{8'd95,  8'd116, 8'd137, 8'd158}, '{8'd90,  8'd110, 8'd130, 8'd150},
    '{8'd85,  8'd104, 8'd123, 8'd142}, '{8'd81,  8'd99,  8'd117, 8'd135},
    '{8'd77,  8'd94,  8'd111, 8'd128}, '{8'd73,  8'd89,  8'd105, 8'd122},
    '{8'd69,  8'd85,  8'd100, 8'd116}, '{8'd66,  8'd80,  8'd95,  8'd110},
    '{8'd62,  8'd76,  8'd90,  8'd104}, '{8'd59,  8'd72,  8'd86,  8'd99},
    '{8'd56,  8'd69,  8'd81,  8'd94},  '{8'd53,  8'd65,  8'd77,  8'd89},
    '{8'd51,  8'd62,  8'd73,  8'd85},  '{8'd48,  8'd59,  8'd69,  8'd80},
    '{8'd46,  8'd56,  8'd66,  8'd76},  '{8'd43,  8'd53,  8'd63,  8'd72},
    '{8'd41,  8'd50,  8'd59,  8'd69},  '{8'd39,  8'd48,  8'd56,  8'd65},
    '{8'd37,  8'd45,  8'd54,  8'd62},  '{8'd35,  8'd43,  8'd51,  8'd59},
    '{8'd33,  8'd41,  8'd48,  8'd56},  '{8'd32,  8'd39,  8'd46,  8'd53},
    '{8'd30,  8'd37,  8'd43,  8'd50},  '{8'd29,  8'd35,  8'd41,  8'd48},
    '{8'd27,  8'd33,  8'd39,  8'd45},  '{8'd26,  8'd31,  8'd37,  8'd43},
    '{8'd24,  8'd30,  8'd35,  8'd41},  '{8'd23,  8'd28,  8'd33,  8'd39},
    '{8'd22,  8'd27,  8'd32,  8'd37},  '{8'd21,  8'd26,  8'd30,  8'd35},
    '{8'd20,  8'd24,  8'd29,  8'd33},  '{8'd19,  8'd23,  8'd27,  8'd31},
    '{8'd18,  8'd22,  8'd26,  8'd30},  '{8'd17,  8'd21,  8'd25,  8'd28},
    '{8'd16,  8'd20,  8'd23,  8'd27},  '{8'd15,  8'd19,  8'd22,  8'd25},
    '{8'd14,  8'd18,  8'd21,  8'd24},  '{8'd14,  8'd17,  8'd20,  8'd23},
    '{8'd13,  8'd16,  8'd19,  8'd22},  '{8'd12,  8'd15,  8'd18,  8'd21},
    '{8'd12,  8'd14,  8'd17,  8'd20},  '{8'd11,  8'd14,  8'd16,  8'd19},
    '{8'd11,  8'd13,  8'd15,  8'd18},  '{8'd10,  8'd12,  8'd15,  8'd17},
    '{8'd10,  8'd12,  8'd14,  8'd16},  '{8'd9,   8'd11,  8'd13,  8'd15},
    '{8'd9,   8'd11,  8'd12,  8'd14},  '{8'd8,   8'd10,  8'd12,  8'd14},
    '{8'd8,   8'd9,   8'd11,  8'd13},  '{8'd7,   8'd9,   8'd11,  8'd12},
    '{8'd7,   8'd9,   8'd10,  8'd12},  '{8'd7,   8'd8,   8'd10,  8'd11},
    '{8'd6,   8'd8,   8'd9,   8'd11},  '{8'd6,   8'd7,   8'd9,   8'd10},
    '{8'd6,   8'd7,   8'd8,   8'd9},   '{8'd2,   8'd2,   8'd2,   8'd2}
  };
  localparam logic [5:0] TRANS_LPS [64] = '{
    6'd0,  6'd0,  6'd1,  6'd2,  6'd2,  6'd4,  6'd4,  6'd5,
    6'd6,  6'd7,  6'd8,  6'd9,  6'd9,  6'd11, 6'd11, 6'd12,
    6'd13, 6'd13, 6'd15, 6'd15, 6'd16, 6'd16, 6'd18, 6'd18,
    6'd19, 6'd19, 6'd21, 6'd21, 6'd22, 6'd22, 6'd23, 6'd24,
    6'd24, 6'd25, 6'd26, 6'd26, 6'd27, 6'd27, 6'd28, 6'd29,
    6'd29, 6'd30, 6'd30, 6'd30, 6'd31, 6'd32, 6'd32, 6'd33,
    6'd33, 6'd33, 6'd34, 6'd34, 6'd35, 6'd35, 6'd35, 6'd36,
    6'd36, 6'd36, 6'd37, 6'd37, 6'd37, 6'd38, 6'd38, 6'd63
  };
endpackage

// File: rtl/decbin_ctx_ram.sv
// decbin_ctx_ram: context store, one write port, registered read with write-first bypass
module decbin_ctx_ram #(parameter int AW = 9) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [6:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [6:0]    rdata
);
  logic [6:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= we && waddr == raddr ? wdata : mem[raddr];
  end
endmodule

// File: rtl/decbin_srv.sv
// decbin_srv: CABAC regular-bin decode server with bit-serial bitstream input
module decbin_srv import decbin_pkg::*; #(parameter int CTX_W = 9) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [CTX_W-1:0] get_inline_mem_addr_i,
  input  logic             get_inline_mem_addr_i_ap_vld,
  output logic             get_inline_mem_addr_i_ap_rdy,
  output logic             get_inline_mem_data_o,
  output logic             get_inline_mem_data_o_ap_vld,
  input  logic             bs_bit_i,
  input  logic             bs_bit_vld_i,
  output logic             bs_bit_rdy_o,
  input  logic             init_i,
  input  logic             ctx_wr_en_i,
  input  logic [CTX_W-1:0] ctx_wr_addr_i,
  input  logic [6:0]       ctx_wr_data_i,
  output logic             busy_o
);
  state_t state, nxt;
  logic [8:0] range_q, offset_q, rlps, rmps, range_n;
  logic [3:0] cnt;
  logic [CTX_W-1:0] ctx;
  logic [6:0] rdata;
  logic [5:0] ps, ps_n;
  logic inited, bin_q, mps, lps, req_hs, bit_hs, wb_en;
  assign get_inline_mem_addr_i_ap_rdy = state == IDLE && inited && !ctx_wr_en_i && !init_i;
  assign bs_bit_rdy_o = state == INIT || state == RENORM;
  assign get_inline_mem_data_o_ap_vld = state == RESP;
  assign get_inline_mem_data_o = state == RESP && bin_q;
  assign busy_o = state != IDLE;
  assign req_hs = get_inline_mem_addr_i_ap_vld && get_inline_mem_addr_i_ap_rdy;
  assign bit_hs = bs_bit_vld_i && bs_bit_rdy_o;
  // a reset landing on the DEC edge must not commit the write-back
  assign wb_en = state == DEC && ap_rst_n;
  always_comb begin
    ps = rdata[6:1];
    mps = rdata[0];
    rlps = {1'b0, LPS_TAB[ps][range_q[7:6]]};
    rmps = range_q - rlps;
    lps = offset_q >= rmps;
    range_n = lps ? rlps : rmps;
    ps_n = lps ? TRANS_LPS[ps] : ps >= 6'd62 ? 6'd62 : ps + 6'd1;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = init_i ? INIT : req_hs ? RD : IDLE;
      INIT:    nxt = bit_hs && cnt == 4'd8 ? IDLE : INIT;
      RD:      nxt = DEC;
      DEC:     nxt = range_n[8] ? RESP : RENORM;
      RENORM:  nxt = bit_hs && range_q[7] ? RESP : RENORM;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      range_q <= '0;
      offset_q <= '0;
      inited <= 1'b0;
      cnt <= '0;
      ctx <= '0;
      bin_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && init_i) begin
        range_q <= RANGE_INIT;
        offset_q <= '0;
        cnt <= '0;
      end
      if (req_hs) ctx <= get_inline_mem_addr_i;
      if (state == INIT && bit_hs) begin
        offset_q <= {offset_q[7:0], bs_bit_i};
        cnt <= cnt + 4'd1;
        inited <= inited | (cnt == 4'd8);
      end
      if (state == DEC) begin
        range_q <= range_n;
        offset_q <= lps ? offset_q - rmps : offset_q;
        bin_q <= mps ^ lps;
      end
      if (state == RENORM && bit_hs) begin
        range_q <= {range_q[7:0], 1'b0};
        offset_q <= {offset_q[7:0], bs_bit_i};
      end
    end
  end
  decbin_ctx_ram #(.AW(CTX_W)) u_ram (
    .clk(ap_clk),
    .we(ctx_wr_en_i | wb_en),
    .waddr(ctx_wr_en_i ? ctx_wr_addr_i : ctx),
    .wdata(ctx_wr_en_i ? ctx_wr_data_i : {ps_n, mps ^ (lps && ps == 6'd0)}),
    .raddr(ctx),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_decbin_srv.sv
// tb_decbin_srv: directed and randomized checks of decbin_srv against an arithmetic CABAC model
module tb_decbin_srv;
  import decbin_pkg::*;
  logic ap_clk = 0, ap_rst_n = 0;
  logic [8:0] addr = '0;
  logic req_vld = 0, rdy, data, data_vld;
  logic bs_bit_i = 0, bs_bit_vld_i = 0, bs_bit_rdy_o;
  logic init_i = 0, ctx_wr_en_i = 0, busy_o;
  logic [8:0] ctx_wr_addr_i = '0;
  logic [6:0] ctx_wr_data_i = '0;
  int n_tests = 0, n_fail = 0, bits_taken = 0;
  logic [6:0] m_ctx [512];
  int m_range = 0, m_offset = 0;

  decbin_srv #(.CTX_W(9)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .get_inline_mem_addr_i(addr), .get_inline_mem_addr_i_ap_vld(req_vld),
    .get_inline_mem_addr_i_ap_rdy(rdy),
    .get_inline_mem_data_o(data), .get_inline_mem_data_o_ap_vld(data_vld),
    .bs_bit_i(bs_bit_i), .bs_bit_vld_i(bs_bit_vld_i), .bs_bit_rdy_o(bs_bit_rdy_o),
    .init_i(init_i), .ctx_wr_en_i(ctx_wr_en_i), .ctx_wr_addr_i(ctx_wr_addr_i),
    .ctx_wr_data_i(ctx_wr_data_i), .busy_o(busy_o)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) if (ap_rst_n && bs_bit_vld_i && bs_bit_rdy_o) bits_taken <= bits_taken + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_init(input logic [8:0] b);
    @(negedge ap_clk);
    init_i = 1;
    @(negedge ap_clk);
    init_i = 0;
    for (int i = 8; i >= 0; i--) begin
      bs_bit_i = b[i];
      bs_bit_vld_i = 1;
      @(negedge ap_clk);
    end
    bs_bit_vld_i = 0;
    m_range = 510;
    m_offset = int'(b);
  endtask

  task automatic wr_ctx(input int a, input logic [6:0] d);
    @(negedge ap_clk);
    ctx_wr_en_i = 1;
    ctx_wr_addr_i = 9'(a);
    ctx_wr_data_i = d;
    @(negedge ap_clk);
    ctx_wr_en_i = 0;
    m_ctx[a] = d;
  endtask

  // vmask[n] is bit-valid presented in the n-th cycle after the request cycle
  task automatic decode(input int a, input logic [63:0] vmask, input logic [5:0] rb,
                        output int lat, output logic bin, output int nb, output logic one_shot);
    int base, k;
    @(negedge ap_clk);
    lat = -1;
    bin = 0;
    base = bits_taken;
    addr = 9'(a);
    req_vld = 1;
    bs_bit_i = rb[0];
    bs_bit_vld_i = vmask[0];
    for (int n = 1; n <= 80; n++) begin
      @(negedge ap_clk);
      req_vld = 0;
      if (data_vld) begin
        lat = n;
        bin = data;
        break;
      end
      k = bits_taken - base;
      bs_bit_i = k < 6 ? rb[k] : 1'b0;
      bs_bit_vld_i = n >= 64 ? 1'b1 : vmask[n];
    end
    bs_bit_vld_i = 0;
    @(negedge ap_clk);
    one_shot = !data_vld;
    nb = bits_taken - base;
  endtask

  // one bin decode straight from the arithmetic-coding rules, updating the model state
  function automatic void model(input int a, input logic [5:0] rb, input logic [63:0] vmask,
                                output logic bin, output int nb, output int lat);
    int ps = int'(m_ctx[a][6:1]);
    int mps = int'(m_ctx[a][0]);
    int rl = int'(LPS_TAB[ps][(m_range / 64) % 4]);
    int rm = m_range - rl;
    if (m_offset >= rm) begin
      bin = (mps == 0);
      m_offset -= rm;
      m_range = rl;
      if (ps == 0) mps = 1 - mps;
      ps = int'(TRANS_LPS[ps]);
    end else begin
      bin = (mps == 1);
      m_range = rm;
      ps = ps < 62 ? ps + 1 : 62;
    end
    m_ctx[a] = {6'(ps), 1'(mps)};
    nb = 0;
    lat = 3;
    for (int c = 3; m_range < 256; c++)
      if (c >= 64 || vmask[c]) begin
        m_range *= 2;
        m_offset = (m_offset * 2 + int'(rb[nb])) % 512;
        nb++;
        lat = c + 1;
      end
  endfunction

  task automatic test_reset;
    ap_rst_n = 0;
    req_vld = 1;
    repeat (3) @(negedge ap_clk);
    n_tests++;
    if ({rdy, data, data_vld, bs_bit_rdy_o, busy_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", {rdy, data, data_vld, bs_bit_rdy_o, busy_o});
    end
    n_tests++;
    if ({dut.range_q, dut.offset_q, dut.inited} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got range %0d offset %0d inited %0d want 0 0 0", dut.range_q, dut.offset_q, dut.inited);
    end
    req_vld = 0;
    ap_rst_n = 1;
  endtask

  task automatic test_no_init;
    int base = bits_taken;
    logic saw_rdy = 0, saw_busy = 0;
    @(negedge ap_clk);
    addr = 9'd3;
    req_vld = 1;
    bs_bit_vld_i = 1;
    repeat (8) begin
      #1;
      saw_rdy |= rdy;
      saw_busy |= busy_o;
      @(negedge ap_clk);
    end
    req_vld = 0;
    bs_bit_vld_i = 0;
    n_tests++;
    if (saw_rdy !== 1'b0) begin n_fail++; $display("FAIL noinit_rdy: got %b want 0", saw_rdy); end
    n_tests++;
    if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL noinit_busy: got %b want 0", saw_busy); end
    n_tests++;
    if (bits_taken != base) begin n_fail++; $display("FAIL noinit_bits: got %0d want 0", bits_taken - base); end
  endtask

  task automatic test_mps_no_renorm;
    int lat, nb;
    logic bin, os;
    do_init(9'd0);
    wr_ctx(5, 7'd0);
    decode(5, '1, 6'd0, lat, bin, nb, os);
    n_tests++;
    if (bin !== 1'b0) begin n_fail++; $display("FAIL mps_bin: got %b want 0", bin); end
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL mps_latency: got %0d want 3", lat); end
    n_tests++;
    if (nb != 0) begin n_fail++; $display("FAIL mps_bits: got %0d want 0", nb); end
    n_tests++;
    if (dut.u_ram.mem[5] !== 7'b0000010) begin n_fail++; $display("FAIL mps_ctx: got %h want 02", dut.u_ram.mem[5]); end
    n_tests++;
    if (dut.range_q !== 9'd270) begin n_fail++; $display("FAIL mps_range: got %0d want 270", dut.range_q); end
    n_tests++;
    if (os !== 1'b1) begin n_fail++; $display("FAIL mps_pulse_width: vld still high after one cycle"); end
  endtask

  task automatic test_lps_renorm(input logic [63:0] vmask, input int exp_lat);
    int lat, nb;
    logic bin, os;
    do_init(9'b100101100);
    wr_ctx(0, 7'd0);
    decode(0, vmask, 6'd0, lat, bin, nb, os);
    n_tests++;
    if (bin !== 1'b1) begin n_fail++; $display("FAIL lps_bin: got %b want 1", bin); end
    n_tests++;
    if (lat != exp_lat) begin n_fail++; $display("FAIL lps_latency: got %0d want %0d", lat, exp_lat); end
    n_tests++;
    if (nb != 1) begin n_fail++; $display("FAIL lps_bits: got %0d want 1", nb); end
    n_tests++;
    if (dut.range_q !== 9'd480 || dut.offset_q !== 9'd60) begin
      n_fail++;
      $display("FAIL lps_regs: got range %0d offset %0d want 480 60", dut.range_q, dut.offset_q);
    end
    n_tests++;
    if (dut.u_ram.mem[0] !== 7'b0000001) begin n_fail++; $display("FAIL lps_ctx: got %h want 01", dut.u_ram.mem[0]); end
    n_tests++;
    if (os !== 1'b1) begin n_fail++; $display("FAIL lps_pulse_width: vld still high after one cycle"); end
  endtask

  task automatic test_collision_bypass;
    logic r;
    do_init(9'd0);
    wr_ctx(9, 7'd0);
    @(negedge ap_clk);
    addr = 9'd9;
    req_vld = 1;
    @(negedge ap_clk);
    req_vld = 0;
    ctx_wr_en_i = 1;
    ctx_wr_addr_i = 9'd9;
    ctx_wr_data_i = 7'b0000001;
    @(negedge ap_clk);
    ctx_wr_en_i = 0;
    @(negedge ap_clk);
    n_tests++;
    if ({data_vld, data} !== 2'b11) begin n_fail++; $display("FAIL bypass_bin: got vld,bin %b want 11", {data_vld, data}); end
    @(negedge ap_clk);
    n_tests++;
    if (dut.u_ram.mem[9] !== 7'b0000011) begin n_fail++; $display("FAIL bypass_ctx: got %h want 03", dut.u_ram.mem[9]); end
    do_init(9'd0);
    wr_ctx(7, 7'd0);
    @(negedge ap_clk);
    addr = 9'd7;
    req_vld = 1;
    @(negedge ap_clk);
    req_vld = 0;
    @(negedge ap_clk);
    ctx_wr_en_i = 1;
    ctx_wr_addr_i = 9'd7;
    ctx_wr_data_i = 7'h55;
    @(negedge ap_clk);
    ctx_wr_en_i = 0;
    n_tests++;
    if (dut.u_ram.mem[7] !== 7'h55) begin n_fail++; $display("FAIL collision_ctx: got %h want 55", dut.u_ram.mem[7]); end
    @(negedge ap_clk);
    ctx_wr_en_i = 1;
    ctx_wr_addr_i = 9'd100;
    #1 r = rdy;
    n_tests++;
    if (r !== 1'b0) begin n_fail++; $display("FAIL rdy_during_ctx_wr: got %b want 0", r); end
    ctx_wr_en_i = 0;
    init_i = 1;
    #1 r = rdy;
    n_tests++;
    if (r !== 1'b0) begin n_fail++; $display("FAIL rdy_during_init: got %b want 0", r); end
    init_i = 0;
    #1 r = rdy;
    n_tests++;
    if (r !== 1'b1) begin n_fail++; $display("FAIL rdy_idle: got %b want 1", r); end
  endtask

  task automatic test_reset_mid;
    int base;
    logic saw_vld = 0, saw_rdy = 0, saw_busy = 0, st;
    do_init(9'b100101100);
    wr_ctx(0, 7'd0);
    @(negedge ap_clk);
    addr = 9'd0;
    req_vld = 1;
    repeat (3) begin
      @(negedge ap_clk);
      req_vld = 0;
    end
    st = busy_o && bs_bit_rdy_o;
    n_tests++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_renorm: got busy&bs_rdy %b want 1", st); end
    ap_rst_n = 0;
    @(negedge ap_clk);
    n_tests++;
    if ({busy_o, data_vld} !== 2'b00) begin n_fail++; $display("FAIL rstmid_abort: got busy,vld %b want 00", {busy_o, data_vld}); end
    ap_rst_n = 1;
    base = bits_taken;
    addr = 9'd0;
    req_vld = 1;
    bs_bit_vld_i = 1;
    repeat (8) begin
      #1;
      saw_vld |= data_vld;
      saw_rdy |= rdy;
      saw_busy |= busy_o;
      @(negedge ap_clk);
    end
    req_vld = 0;
    bs_bit_vld_i = 0;
    n_tests++;
    if ({saw_vld, saw_rdy, saw_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_after: got vld,rdy,busy seen %b want 000", {saw_vld, saw_rdy, saw_busy});
    end
    n_tests++;
    if (bits_taken != base) begin n_fail++; $display("FAIL rstmid_bits: got %0d want 0", bits_taken - base); end
    do_init(9'd0);
    wr_ctx(2, 7'h10);
    @(negedge ap_clk);
    addr = 9'd2;
    req_vld = 1;
    @(negedge ap_clk);
    req_vld = 0;
    @(negedge ap_clk);
    ap_rst_n = 0;
    @(negedge ap_clk);
    ap_rst_n = 1;
    n_tests++;
    if (dut.u_ram.mem[2] !== 7'h10) begin n_fail++; $display("FAIL rst_in_dec_ctx: got %h want 10", dut.u_ram.mem[2]); end
  endtask

  task automatic test_random;
    int addrs [8];
    int lat, nb, e_lat, e_nb, a;
    logic bin, e_bin, os;
    logic [5:0] rb;
    logic [63:0] vm;
    for (int r = 0; r < 4; r++) begin
      do_init(9'($urandom_range(0, 509)));
      for (int i = 0; i < 8; i++) begin
        addrs[i] = $urandom_range(0, 511);
        wr_ctx(addrs[i], {6'($urandom_range(0, 62)), 1'($urandom_range(0, 1))});
      end
      for (int j = 0; j < 12; j++) begin
        a = addrs[$urandom_range(0, 7)];
        rb = 6'($urandom);
        vm = {$urandom, $urandom} | {$urandom, $urandom};
        decode(a, vm, rb, lat, bin, nb, os);
        model(a, rb, vm, e_bin, e_nb, e_lat);
        n_tests++;
        if (bin !== e_bin) begin n_fail++; $display("FAIL rand_bin ctx %0d: got %b want %b", a, bin, e_bin); end
        n_tests++;
        if (lat != e_lat) begin n_fail++; $display("FAIL rand_latency ctx %0d: got %0d want %0d", a, lat, e_lat); end
        n_tests++;
        if (nb != e_nb) begin n_fail++; $display("FAIL rand_bits ctx %0d: got %0d want %0d", a, nb, e_nb); end
        n_tests++;
        if (dut.range_q !== 9'(m_range) || dut.offset_q !== 9'(m_offset)) begin
          n_fail++;
          $display("FAIL rand_regs: got range %0d offset %0d want %0d %0d", dut.range_q, dut.offset_q, m_range, m_offset);
        end
        n_tests++;
        if (dut.u_ram.mem[a] !== m_ctx[a]) begin n_fail++; $display("FAIL rand_ctx %0d: got %h want %h", a, dut.u_ram.mem[a], m_ctx[a]); end
        n_tests++;
        if (os !== 1'b1) begin n_fail++; $display("FAIL rand_pulse_width: vld still high after one cycle"); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_init();
    test_mps_no_renorm();
    test_lps_renorm('1, 4);
    test_lps_renorm(~64'h78, 8);
    test_collision_bypass();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decbin_srv.md
DECBIN_SRV -- requirements
Module: decbin_srv

Interface
REQ-001 SHALL have parameter CTX_W, default 9, context address width (512 contexts).
REQ-002 SHALL have ports: ap_clk  in  1  sole clock; ap_rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: get_inline_mem_addr_i  in  CTX_W  request context index; get_inline_mem_addr_i_ap_vld  in  1  request valid; get_inline_mem_addr_i_ap_rdy  out  1  request accepted when high with vld.
REQ-004 SHALL have ports: get_inline_mem_data_o  out  1  decoded bin; get_inline_mem_data_o_ap_vld  out  1  one-cycle pulse, no backpressure.
REQ-005 SHALL have ports: bs_bit_i  in  1  next bitstream bit; bs_bit_vld_i  in  1  bit valid; bs_bit_rdy_o  out  1  bit consumed when high with vld.
REQ-006 SHALL have ports: init_i  in  1  engine-init pulse; ctx_wr_en_i  in  1, ctx_wr_addr_i  in  CTX_W, ctx_wr_data_i  in  7  {pStateIdx[5:0], valMps}; busy_o  out  1  state != IDLE.

Function
REQ-007 SHALL hold registers range[8:0], offset[8:0], inited flag; FSM states IDLE, INIT, RD, DEC, RENORM, RESP.
REQ-008 SHALL assert ap_rdy = (state==IDLE) & inited & ~ctx_wr_en_i; handshake = vld & rdy.
REQ-009 IDLE: init_i -> INIT with range=510, offset=0, bit count 0; init_i ignored outside IDLE; init_i wins over a same-cycle request (rdy low).
REQ-010 INIT: consume 9 bits MSB-first, offset=(offset<<1)|bit per handshaked bit, stall while bs_bit_vld_i low; after 9th bit set inited, -> IDLE.
REQ-011 Request handshake: latch ctx, issue context RAM read, -> RD (1-cycle read latency), then -> DEC.
REQ-012 DEC: q=range[7:6]; rLPS=LPS_TAB[pState][q]; rMPS=range-rLPS (9-bit, no underflow by construction).
REQ-013 DEC, offset>=rMPS: bin=~valMps, offset-=rMPS, range=rLPS; if pState==0 flip valMps; pState=TRANS_LPS[pState].
REQ-014 DEC, offset<rMPS: bin=valMps, range=rMPS; pState=min(pState+1,62).
REQ-015 DEC SHALL write updated context back in the same cycle; -> RENORM if new range<256, else RESP.
REQ-016 RENORM: per handshaked bit range<<=1, offset=(offset<<1)|bit; stall on ~bs_bit_vld_i; -> RESP once range>=256 (max 6 bits for LPS, 1 for MPS).
REQ-017 bs_bit_rdy_o SHALL be high only in INIT and RENORM.
REQ-018 RESP: data_o_ap_vld=1 for exactly one cycle with bin, -> IDLE; latency = 3 + N_renorm + stall cycles after request handshake edge.
REQ-019 External context write SHALL be accepted in any state; same-cycle collision with DEC write-back: external write wins, write-back dropped.
REQ-020 Read in RD of an address written by ctx_wr in the previous cycle SHALL return the new data (write-first bypass).

Reset
REQ-021 On ap_rst_n low at clock edge: state=IDLE, inited=0, range=0, offset=0, all outputs 0; context RAM contents not cleared.
REQ-022 Reset mid-operation SHALL abort without data_o_ap_vld pulse or context write-back.

Structure
REQ-023 decbin_pkg SHALL hold FSM enum, LPS_TAB[64][4] (8-bit), TRANS_LPS[64] (6-bit), init constant 510.
REQ-024 Context storage SHALL be sub-module decbin_ctx_ram: 2^CTX_W x 7, one write port (arbitrated), one read port, 1-cycle read, bypass per REQ-020.

Verification
REQ-025 Init with 9 zero bits, ctx 5 = {pState 0, valMps 0}, request ctx 5 -> bin 0, no renorm, vld pulse 3 cycles after handshake, ctx 5 = {1,0}, range=270.
REQ-026 Init with bits 100101100 (offset 300), ctx 0 = {0,0}, request -> LPS: bin 1, offset 30, range 240, 1 renorm bit, ctx 0 = {0,1}.
REQ-027 Same as REQ-026 with bs_bit_vld_i low 4 cycles during RENORM -> vld pulse delayed exactly 4 cycles, no extra bit consumed.
REQ-028 ctx_wr_en_i to address 7 in same cycle as DEC write-back to 7 -> RAM holds external data; rdy low in any IDLE cycle with ctx_wr_en_i.
REQ-029 ap_rst_n low during RENORM -> no vld pulse, busy_o=0 next cycle, requests refused until re-init.
REQ-030 Request before any init -> rdy stays low, no bitstream bits consumed.
